fill_sequencer: RTL and testbench

Sequencing controller for the pill-bottling line. It runs the fill datapath: BCD pill and bottle counters, hopper-starvation watchdog, bottle-switch timer and conveyor check. It sits between the front-panel setting logic, which supplies the BCD targets and start/ack pulses, and the display/beeper logic, which consumes the state code, the counts and the event pulses. The state encoding matches the 7-segment status digit codes 0–5.

---
 rtl/fill_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_fill_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_sequencer.sv
// fill_sequencer: pill-bottling line sequencer.
// Runs the BCD pill/bottle counters, the hopper-starvation watchdog, the
// bottle-switch timer and the conveyor check. The state code doubles as the
// 7-segment status digit (0 SETTING .. 5 FATAL).
// Ports:
//   clk_1khz, switch_clr      1 kHz clock, async active-low reset
//   start, ack                one-cycle panel pulses
//   estop                     synchronised emergency-stop level
//   target_pills/_bottles     BCD targets, latched on an accepted start
//   pill_pulse, conveyor_ok   hopper pill pulse, conveyor health level
//   state, now_pills, now_bottles, fill_en, conveyor_run, err_code,
//   bottle_done               registered status/drive outputs
module fill_sequencer #(
  parameter int unsigned HOPPER_TIMEOUT_MS = 3000,
  parameter int unsigned SWITCH_MS         = 2000
) (
  input  logic        clk_1khz,
  input  logic        switch_clr,
  input  logic        start,
  input  logic        ack,
  input  logic        estop,
  input  logic [11:0] target_pills,
  input  logic [7:0]  target_bottles,
  input  logic        pill_pulse,
  input  logic        conveyor_ok,
  output logic [2:0]  state,
  output logic [11:0] now_pills,
  output logic [7:0]  now_bottles,
  output logic        fill_en,
  output logic        conveyor_run,
  output logic [1:0]  err_code,
  output logic        bottle_done
);

  localparam int unsigned HW = $clog2(HOPPER_TIMEOUT_MS + 1);
  localparam int unsigned SW = $clog2(SWITCH_MS + 1);
  localparam logic [HW-1:0] HOP_LOAD = HW'(HOPPER_TIMEOUT_MS);
  localparam logic [SW-1:0] SW_LOAD  = SW'(SWITCH_MS);

  typedef enum logic [2:0] {
    ST_SETTING   = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_SWITCHING = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERROR     = 3'd4,
    ST_FATAL     = 3'd5
  } st_e;

  st_e           state_q, state_d;
  logic [11:0]   pills_q, pills_d, tp_q, tp_d, pill_inc;
  logic [7:0]    bottles_q, bottles_d, tb_q, tb_d, bot_inc;
  logic [HW-1:0] hop_q, hop_d;
  logic [SW-1:0] sw_q, sw_d;
  logic [1:0]    err_q, err_d;
  logic          done_q, done_d;
  logic          fill_en_q, conv_q;
  logic          count_pill;
  logic          targets_ok;

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [11:0] bcd_inc3(input logic [11:0] v);
    logic [11:0] r;
    r       = v;
    r[3:0]  = digit_inc(v[3:0]);
    if (v[3:0] == 4'd9) begin
      r[7:4] = digit_inc(v[7:4]);
      if (v[7:4] == 4'd9) r[11:8] = digit_inc(v[11:8]);
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    logic [7:0] r;
    r      = v;
    r[3:0] = digit_inc(v[3:0]);
    if (v[3:0] == 4'd9) r[7:4] = digit_inc(v[7:4]);
    return r;
  endfunction

  assign pill_inc   = bcd_inc3(pills_q);
  assign bot_inc    = bcd_inc2(bottles_q);
  assign targets_ok = (target_pills != '0) && (target_bottles != '0) &&
                      (target_pills[3:0] <= 4'd9) && (target_pills[7:4] <= 4'd9) &&
                      (target_pills[11:8] <= 4'd9) &&
                      (target_bottles[3:0] <= 4'd9) && (target_bottles[7:4] <= 4'd9);

  always_comb begin
    state_d    = state_q;
    pills_d    = pills_q;
    bottles_d  = bottles_q;
    tp_d       = tp_q;
    tb_d       = tb_q;
    hop_d      = hop_q;
    sw_d       = sw_q;
    err_d      = err_q;
    done_d     = 1'b0;
    count_pill = 1'b0;

    case (state_q)
      ST_SETTING: begin
        if (start && targets_ok) begin
          tp_d      = target_pills;
          tb_d      = target_bottles;
          pills_d   = '0;
          bottles_d = '0;
          hop_d     = HOP_LOAD;
          sw_d      = '0;
          state_d   = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (pill_pulse) begin
          count_pill = 1'b1;
        end else if (hop_q <= HW'(1)) begin
          hop_d   = '0;
          err_d   = 2'd1;
          state_d = ST_ERROR;
        end else begin
          hop_d = hop_q - HW'(1);
        end
      end
      ST_SWITCHING: begin
        if (sw_q <= SW'(1)) begin
          sw_d = '0;
          if (conveyor_ok) begin
            pills_d = '0;
            hop_d   = HOP_LOAD;
            state_d = ST_RUNNING;
          end else begin
            err_d   = 2'd2;
            state_d = ST_ERROR;
          end
        end else begin
          sw_d = sw_q - SW'(1);
        end
      end
      ST_ERROR: begin
        if (ack) begin
          err_d   = '0;
          state_d = ST_SETTING;
        end else if (err_q == 2'd1 && pill_pulse) begin
          err_d      = '0;
          count_pill = 1'b1;
        end else if (err_q == 2'd2 && conveyor_ok) begin
          err_d   = '0;
          pills_d = '0;
          hop_d   = HOP_LOAD;
          state_d = ST_RUNNING;
        end
      end
      ST_DONE: begin
        if (ack) state_d = ST_SETTING;
      end
      ST_FATAL: begin
        if (ack && !estop) begin
          err_d   = '0;
          state_d = ST_SETTING;
        end
      end
      default: state_d = ST_SETTING;
    endcase

    // Pill counting is shared by RUNNING and hopper-starved ERROR so both
    // take the identical completion path.
    if (count_pill) begin
      pills_d = pill_inc;
      hop_d   = HOP_LOAD;
      if (pill_inc == tp_q) begin
        bottles_d = bot_inc;
        done_d    = 1'b1;
        if (bot_inc == tb_q) begin
          state_d = ST_DONE;
        end else begin
          sw_d    = SW_LOAD;
          state_d = ST_SWITCHING;
        end
      end else begin
        state_d = ST_RUNNING;
      end
    end

    // Emergency stop freezes everything except the state itself.
    if (estop) begin
      state_d   = ST_FATAL;
      pills_d   = pills_q;
      bottles_d = bottles_q;
      tp_d      = tp_q;
      tb_d      = tb_q;
      hop_d     = hop_q;
      sw_d      = sw_q;
      err_d     = err_q;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      state_q   <= ST_SETTING;
      pills_q   <= '0;
      bottles_q <= '0;
      tp_q      <= '0;
      tb_q      <= '0;
      hop_q     <= '0;
      sw_q      <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      fill_en_q <= 1'b0;
      conv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pills_q   <= pills_d;
      bottles_q <= bottles_d;
      tp_q      <= tp_d;
      tb_q      <= tb_d;
      hop_q     <= hop_d;
      sw_q      <= sw_d;
      err_q     <= err_d;
      done_q    <= done_d;
      fill_en_q <= (state_d == ST_RUNNING);
      conv_q    <= (state_d == ST_SWITCHING);
    end
  end

  assign state        = state_q;
  assign now_pills    = pills_q;
  assign now_bottles  = bottles_q;
  assign fill_en      = fill_en_q;
  assign conveyor_run = conv_q;
  assign err_code     = err_q;
  assign bottle_done  = done_q;

endmodule

// File: tb/tb_fill_sequencer.sv
// tb_fill_sequencer: directed bench for fill_sequencer with
// HOPPER_TIMEOUT_MS=20 and SWITCH_MS=10. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_fill_sequencer;

  logic        clk_1khz = 1'b0;
  logic        switch_clr;
  logic        start, ack, estop, pill_pulse, conveyor_ok;
  logic [11:0] target_pills;
  logic [7:0]  target_bottles;
  logic [2:0]  state;
  logic [11:0] now_pills;
  logic [7:0]  now_bottles;
  logic        fill_en, conveyor_run, bottle_done;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int base;
  int n;

  fill_sequencer #(.HOPPER_TIMEOUT_MS(20), .SWITCH_MS(10)) dut (
    .clk_1khz       (clk_1khz),
    .switch_clr     (switch_clr),
    .start          (start),
    .ack            (ack),
    .estop          (estop),
    .target_pills   (target_pills),
    .target_bottles (target_bottles),
    .pill_pulse     (pill_pulse),
    .conveyor_ok    (conveyor_ok),
    .state          (state),
    .now_pills      (now_pills),
    .now_bottles    (now_bottles),
    .fill_en        (fill_en),
    .conveyor_run   (conveyor_run),
    .err_code       (err_code),
    .bottle_done    (bottle_done)
  );

  always #5 clk_1khz = ~clk_1khz;

  always @(negedge clk_1khz) if (bottle_done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk_1khz);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk_1khz); start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; @(negedge clk_1khz); ack = 1'b0;
  endtask

  task automatic pill();
    pill_pulse = 1'b1; @(negedge clk_1khz); pill_pulse = 1'b0;
  endtask

  // Counts falling edges on which state stays at s, bounded.
  task automatic count_state(input logic [2:0] s, output int cnt);
    cnt = 0;
    while (state === s && cnt < 200) begin
      cnt++;
      @(negedge clk_1khz);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_pills"}, now_pills, 0);
    check({tag, "_bottles"}, now_bottles, 0);
    check({tag, "_fill"}, fill_en, 0);
    check({tag, "_conv"}, conveyor_run, 0);
    check({tag, "_err"}, err_code, 0);
    check({tag, "_done"}, bottle_done, 0);
  endtask

  initial begin
    start = 0; ack = 0; estop = 0; pill_pulse = 0; conveyor_ok = 1;
    target_pills = 12'h003; target_bottles = 8'h02;
    switch_clr = 1'b1;
    #1 switch_clr = 1'b0;
    #1 check_reset_vals("rst");
    @(negedge clk_1khz); switch_clr = 1'b1;
    @(negedge clk_1khz);
    check("rst_idle", state, 0);

    // Normal batch 003 pills x 02 bottles
    base = done_cnt;
    pulse_start();
    check("t1_run", state, 1);
    check("t1_fill", fill_en, 1);
    target_pills = 12'h999; target_bottles = 8'h99;   // must be ignored now
    pill(); check("t1_p1", now_pills, 12'h001); idle(2);
    pill(); check("t1_p2", now_pills, 12'h002); idle(2);
    pill();
    check("t1_sw", state, 2);
    check("t1_p3", now_pills, 12'h003);
    check("t1_b1", now_bottles, 8'h01);
    check("t1_bd", bottle_done, 1);
    check("t1_conv", conveyor_run, 1);
    check("t1_fill0", fill_en, 0);
    count_state(3'd2, n);
    check("t1_swlen", n, 10);
    check("t1_back", state, 1);
    check("t1_clr", now_pills, 12'h000);
    check("t1_conv0", conveyor_run, 0);
    pill(); idle(2); pill(); idle(2); pill();
    check("t1_done", state, 3);
    check("t1_b2", now_bottles, 8'h02);
    check("t1_p3b", now_pills, 12'h003);
    idle(1);
    check("t1_bd0", bottle_done, 0);
    check("t1_bdcnt", done_cnt - base, 2);
    pulse_start();
    check("t1_startign", state, 3);
    pulse_ack();
    check("t1_ack", state, 0);
    check("t1_hold", now_bottles, 8'h02);

    // BCD carry, 100 pills x 1 bottle
    target_pills = 12'h100; target_bottles = 8'h01;
    pulse_start();
    for (int i = 1; i <= 100; i++) begin
      pill();
      if (i < 100) check($sformatf("t2_bcd%0d", i), now_pills, to_bcd(i));
      idle(1);
    end
    check("t2_done", state, 3);
    check("t2_p100", now_pills, 12'h100);
    check("t2_b1", now_bottles, 8'h01);
    pulse_ack();

    // Hopper starvation and recovery
    target_pills = 12'h003; target_bottles = 8'h02;
    pulse_start();
    count_state(3'd1, n);
    check("t3_hoplen", n, 20);
    check("t3_err", state, 4);
    check("t3_code", err_code, 1);
    check("t3_fill0", fill_en, 0);
    pill();
    check("t3_rec", state, 1);
    check("t3_code0", err_code, 0);
    check("t3_p1", now_pills, 12'h001);
    idle(19);
    check("t3_prelast", state, 1);
    pill();                          // arrives in the last watchdog cycle
    check("t3_last", state, 1);
    check("t3_p2", now_pills, 12'h002);

    // Conveyor fault
    pill();
    check("t4_sw", state, 2);
    conveyor_ok = 1'b0;
    count_state(3'd2, n);
    check("t4_swlen", n, 10);
    check("t4_err", state, 4);
    check("t4_code", err_code, 2);
    check("t4_b1", now_bottles, 8'h01);
    conveyor_ok = 1'b1;
    @(negedge clk_1khz);
    check("t4_rec", state, 1);
    check("t4_clr", now_pills, 12'h000);
    check("t4_code0", err_code, 0);

    // Emergency stop
    idle(2);
    estop = 1'b1;
    @(negedge clk_1khz);
    check("t5_fatal", state, 5);
    check("t5_fill0", fill_en, 0);
    pulse_ack();
    check("t5_ackign", state, 5);
    estop = 1'b0;
    @(negedge clk_1khz);
    check("t5_hold", state, 5);
    pulse_ack();
    check("t5_ack", state, 0);
    check("t5_code0", err_code, 0);

    // estop keeps err_code; ack beats recovering pill in ERROR
    pulse_start();
    count_state(3'd1, n);
    check("t5b_err", err_code, 1);
    estop = 1'b1;
    @(negedge clk_1khz);
    check("t5b_fatal", state, 5);
    check("t5b_keep", err_code, 1);
    estop = 1'b0;
    pulse_ack();
    check("t5b_set", state, 0);
    pulse_start();
    count_state(3'd1, n);
    ack = 1'b1; pill_pulse = 1'b1;
    @(negedge clk_1khz);
    ack = 1'b0; pill_pulse = 1'b0;
    check("t5c_ackwin", state, 0);
    check("t5c_nocount", now_pills, 12'h000);

    // Rejected starts and asynchronous reset
    target_pills = 12'h000;
    pulse_start();
    check("t6_zero", state, 0);
    target_pills = 12'h0A3;
    pulse_start();
    check("t6_digitA", state, 0);
    target_pills = 12'h003; target_bottles = 8'h00;
    pulse_start();
    check("t6_zerob", state, 0);
    target_bottles = 8'h02;
    pulse_start();
    check("t6_ok", state, 1);
    pill(); idle(1); pill(); idle(1); pill();
    check("t6_sw", state, 2);
    idle(3);
    #1 switch_clr = 1'b0;
    #1 check_reset_vals("t6_rst");
    @(negedge clk_1khz); switch_clr = 1'b1;
    @(negedge clk_1khz);
    pulse_start();
    check("t6_fresh", state, 1);
    check("t6_freshp", now_pills, 12'h000);
    check("t6_freshb", now_bottles, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
